// File: rtl/sp_ram_arbiter.sv
// Two-port round-robin front end for a single-port synchronous RAM: arbitrates A/B
// requests, sequences cs/we/oe/addr and the shared data bus, and returns one response per request.
module sp_ram_arbiter #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  a_req_valid,
    output logic                  a_req_ready,
    input  logic                  a_req_we,
    input  logic [ADDR_WIDTH-1:0] a_req_addr,
    input  logic [DATA_WIDTH-1:0] a_req_wdata,
    output logic                  a_rsp_valid,
    output logic [DATA_WIDTH-1:0] a_rsp_rdata,
    output logic                  a_rsp_err,

    input  logic                  b_req_valid,
    output logic                  b_req_ready,
    input  logic                  b_req_we,
    input  logic [ADDR_WIDTH-1:0] b_req_addr,
    input  logic [DATA_WIDTH-1:0] b_req_wdata,
    output logic                  b_rsp_valid,
    output logic [DATA_WIDTH-1:0] b_rsp_rdata,
    output logic                  b_rsp_err,

    output logic [ADDR_WIDTH-1:0] ram_addr,
    inout  wire  [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, WRITE, RD_ADDR, RD_DATA} state_t;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    state_t                  state, state_next;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [DATA_WIDTH-1:0]   req_wdata;
    logic                    req_port;
    logic                    last_grant;

    logic                    grant_valid, grant_port;
    logic                    sel_we;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_wdata;
    logic                    addr_bad;

    logic                    rsp_fire, rsp_err, rsp_port;
    logic [DATA_WIDTH-1:0]   rsp_data;

    // Arbitration only happens in IDLE; on a tie the port that did not win last time goes.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        grant_valid = 1'b0;
        grant_port  = PORT_A;
        if (state == IDLE) begin
            if (a_req_valid && b_req_valid) begin
                grant_valid = 1'b1;
                grant_port  = ~last_grant;
            end else if (a_req_valid) begin
                grant_valid = 1'b1;
                grant_port  = PORT_A;
            end else if (b_req_valid) begin
                grant_valid = 1'b1;
                grant_port  = PORT_B;
            end
        end
    end

    assign a_req_ready = grant_valid && (grant_port == PORT_A);
    assign b_req_ready = grant_valid && (grant_port == PORT_B);

    assign sel_we    = (grant_port == PORT_B) ? b_req_we    : a_req_we;
    assign sel_addr  = (grant_port == PORT_B) ? b_req_addr  : a_req_addr;
    assign sel_wdata = (grant_port == PORT_B) ? b_req_wdata : a_req_wdata;
    assign addr_bad  = {1'b0, sel_addr} >= (ADDR_WIDTH + 1)'(DEPTH);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_valid && !addr_bad) state_next = sel_we ? WRITE : RD_ADDR;
            WRITE:   state_next = IDLE;
            RD_ADDR: state_next = RD_DATA;
            RD_DATA: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Response source: rejected address at accept, write at end of WRITE, read data at end of RD_DATA.
    always_comb begin
        rsp_fire = 1'b0;
        rsp_err  = 1'b0;
        rsp_port = req_port;
        rsp_data = '0;
        case (state)
            IDLE: if (grant_valid && addr_bad) begin
                rsp_fire = 1'b1;
                rsp_err  = 1'b1;
                rsp_port = grant_port;
            end
            WRITE:   rsp_fire = 1'b1;
            RD_DATA: begin
                rsp_fire = 1'b1;
                rsp_data = ram_data;
            end
            default: ;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            last_grant  <= PORT_B;
            a_rsp_valid <= 1'b0;
            a_rsp_err   <= 1'b0;
            a_rsp_rdata <= '0;
            b_rsp_valid <= 1'b0;
            b_rsp_err   <= 1'b0;
            b_rsp_rdata <= '0;
        end else begin
            state       <= state_next;
            a_rsp_valid <= rsp_fire && (rsp_port == PORT_A);
            a_rsp_err   <= rsp_fire && (rsp_port == PORT_A) && rsp_err;
            a_rsp_rdata <= (rsp_fire && (rsp_port == PORT_A)) ? rsp_data : '0;
            b_rsp_valid <= rsp_fire && (rsp_port == PORT_B);
            b_rsp_err   <= rsp_fire && (rsp_port == PORT_B) && rsp_err;
            b_rsp_rdata <= (rsp_fire && (rsp_port == PORT_B)) ? rsp_data : '0;
            if (grant_valid) last_grant <= grant_port;
        end
    end

    // NOTE: the request payload is deliberately not reset; it is only observed while state != IDLE.
    always_ff @(posedge clk) begin
        if (grant_valid) begin
            req_addr  <= sel_addr;
            req_wdata <= sel_wdata;
            req_port  <= grant_port;
        end
    end

    assign busy     = (state != IDLE);
    assign ram_cs   = (state != IDLE);
    assign ram_we   = (state == WRITE);
    assign ram_oe   = (state == RD_DATA);
    assign ram_addr = (state != IDLE) ? req_addr : '0;
    assign ram_data = (state == WRITE) ? req_wdata : 'z;

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Directed bench for sp_ram_arbiter with a behavioural single-port synchronous RAM on the pins.
module tb_sp_ram_arbiter;

    localparam int AW = 4;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_req_valid, a_req_ready, a_req_we;
    logic [AW-1:0] a_req_addr;
    logic [DW-1:0] a_req_wdata;
    logic          a_rsp_valid, a_rsp_err;
    logic [DW-1:0] a_rsp_rdata;
    logic          b_req_valid, b_req_ready, b_req_we;
    logic [AW-1:0] b_req_addr;
    logic [DW-1:0] b_req_wdata;
    logic          b_rsp_valid, b_rsp_err;
    logic [DW-1:0] b_rsp_rdata;
    logic [AW-1:0] ram_addr;
    wire  [DW-1:0] ram_data;
    logic          ram_cs, ram_we, ram_oe, busy;

    int n_checks = 0;
    int n_fail   = 0;
    int bus_conflicts = 0;
    int rsp_bad  = 0;
    int cs_count = 0;

    sp_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(8)) dut (
        .clk(clk), .rst(rst),
        .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_we(a_req_we),
        .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata),
        .a_rsp_valid(a_rsp_valid), .a_rsp_rdata(a_rsp_rdata), .a_rsp_err(a_rsp_err),
        .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_we(b_req_we),
        .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata),
        .b_rsp_valid(b_rsp_valid), .b_rsp_rdata(b_rsp_rdata), .b_rsp_err(b_rsp_err),
        .ram_addr(ram_addr), .ram_data(ram_data), .ram_cs(ram_cs), .ram_we(ram_we),
        .ram_oe(ram_oe), .busy(busy)
    );

    always #5 clk = ~clk;

    // RAM model: registered output loaded on cs&!we, driven onto the bus only while oe.
    logic [DW-1:0] mem [16];
    logic [DW-1:0] ram_q;
    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_we) mem[ram_addr] <= ram_data;
            else        ram_q         <= mem[ram_addr];
        end
    end
    assign ram_data = (ram_cs && ram_oe && !ram_we) ? ram_q : 'z;

    always @(negedge clk) begin
        if (ram_we && ram_oe) bus_conflicts++;
        if (ram_cs) cs_count++;
        if ((!a_rsp_valid && (a_rsp_rdata != '0 || a_rsp_err)) ||
            (!b_rsp_valid && (b_rsp_rdata != '0 || b_rsp_err)) ||
            (a_rsp_valid && b_rsp_valid))
            rsp_bad++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, wait for acceptance and for its response; lat counts edges after accept.
    task automatic do_txn(input logic port, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, output logic [DW-1:0] rdata,
                          output logic err, output int lat);
        int waited = 0;
        if (!port) begin
            a_req_valid = 1'b1; a_req_we = we; a_req_addr = addr; a_req_wdata = wdata;
        end else begin
            b_req_valid = 1'b1; b_req_we = we; b_req_addr = addr; b_req_wdata = wdata;
        end
        #1;
        while (!(port ? b_req_ready : a_req_ready) && waited < 20) begin
            tick();
            waited++;
        end
        check("txn_ready", port ? b_req_ready : a_req_ready, 1);
        tick();
        a_req_valid = 1'b0;
        b_req_valid = 1'b0;
        lat = 0;
        while (!(port ? b_rsp_valid : a_rsp_valid) && lat < 10) begin
            tick();
            lat++;
        end
        check("txn_rsp_seen", port ? b_rsp_valid : a_rsp_valid, 1);
        rdata = port ? b_rsp_rdata : a_rsp_rdata;
        err   = port ? b_rsp_err   : a_rsp_err;
    endtask

    initial begin
        logic [DW-1:0] rd;
        logic          er;
        int            lat;
        int            g[$];
        int            a_cnt, b_cnt, cnt, cs_before;

        rst = 1'b1;
        a_req_valid = 0; a_req_we = 0; a_req_addr = '0; a_req_wdata = '0;
        b_req_valid = 0; b_req_we = 0; b_req_addr = '0; b_req_wdata = '0;
        tick(); tick();
        check("rst_busy", busy, 0);
        check("rst_cs", ram_cs, 0);
        check("rst_we_oe", {ram_we, ram_oe}, 0);
        check("rst_addr", ram_addr, 0);
        check("rst_rsp", {a_rsp_valid, a_rsp_err, b_rsp_valid, b_rsp_err}, 0);
        check("rst_rdata", {a_rsp_rdata, b_rsp_rdata}, 0);
        rst = 1'b0;
        tick();

        // 1: A write then read of address 5, cycle by cycle
        a_req_valid = 1; a_req_we = 1; a_req_addr = 4'h5; a_req_wdata = 32'hDEADBEEF;
        #1;
        check("t1_w_ready", a_req_ready, 1);
        tick();
        a_req_valid = 0;
        check("t1_write_pins", {ram_cs, ram_we, ram_oe}, 3'b110);
        check("t1_write_addr", ram_addr, 4'h5);
        check("t1_write_data", ram_data, 32'hDEADBEEF);
        check("t1_w_rsp_early", a_rsp_valid, 0);
        tick();
        check("t1_w_rsp", {a_rsp_valid, a_rsp_err}, 2'b10);
        check("t1_w_rdata", a_rsp_rdata, 0);
        check("t1_w_idle", busy, 0);
        a_req_valid = 1; a_req_we = 0; a_req_addr = 4'h5;
        #1;
        check("t1_r_ready", a_req_ready, 1);
        tick();
        a_req_valid = 0;
        check("t1_rd_addr_pins", {ram_cs, ram_we, ram_oe}, 3'b100);
        check("t1_r_rsp_early", a_rsp_valid, 0);
        tick();
        check("t1_rd_data_pins", {ram_cs, ram_we, ram_oe}, 3'b101);
        check("t1_rd_data_addr", ram_addr, 4'h5);
        check("t1_r_rsp_early2", a_rsp_valid, 0);
        tick();
        check("t1_r_rsp", {a_rsp_valid, a_rsp_err}, 2'b10);
        check("t1_r_rdata", a_rsp_rdata, 32'hDEADBEEF);
        check("t1_b_quiet", {b_rsp_valid, b_rsp_rdata}, 0);
        tick();
        check("t1_rsp_drop", {a_rsp_valid, a_rsp_rdata}, 0);

        // 2: both ports reading continuously alternate A,B,A,B after reset
        do_txn(0, 1, 4'h1, 32'h1111_0001, rd, er, lat);
        do_txn(1, 1, 4'h2, 32'h2222_0002, rd, er, lat);
        tick();
        rst = 1; tick(); rst = 0;
        a_req_valid = 1; a_req_we = 0; a_req_addr = 4'h1;
        b_req_valid = 1; b_req_we = 0; b_req_addr = 4'h2;
        #1;
        a_cnt = 0; b_cnt = 0; cnt = 0;
        for (int cyc = 0; cyc < 30 && g.size() < 4; cyc++) begin
            if (a_req_ready && b_req_ready) cnt++;
            if (a_req_ready) g.push_back(0);
            if (b_req_ready) g.push_back(1);
            if (a_rsp_valid) begin a_cnt++; check("t2_a_rdata", a_rsp_rdata, 32'h1111_0001); end
            if (b_rsp_valid) begin b_cnt++; check("t2_b_rdata", b_rsp_rdata, 32'h2222_0002); end
            tick();
        end
        a_req_valid = 0; b_req_valid = 0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            if (a_rsp_valid) begin a_cnt++; check("t2_a_rdata", a_rsp_rdata, 32'h1111_0001); end
            if (b_rsp_valid) begin b_cnt++; check("t2_b_rdata", b_rsp_rdata, 32'h2222_0002); end
            tick();
        end
        check("t2_grant_count", g.size(), 4);
        for (int i = 0; i < g.size(); i++) check($sformatf("t2_grant%0d", i), g[i], i % 2);
        check("t2_dual_ready", cnt, 0);
        check("t2_rsp_counts", {a_cnt[7:0], b_cnt[7:0]}, 16'h0202);

        // 3: out-of-range read from B is rejected without touching the RAM
        cs_before = cs_count;
        b_req_valid = 1; b_req_we = 0; b_req_addr = 4'hC;
        #1;
        check("t3_ready", b_req_ready, 1);
        tick();
        b_req_valid = 0;
        check("t3_rsp", {b_rsp_valid, b_rsp_err}, 2'b11);
        check("t3_rdata", b_rsp_rdata, 0);
        check("t3_idle", {busy, ram_cs}, 0);
        tick();
        check("t3_rsp_drop", {b_rsp_valid, b_rsp_err}, 0);
        tick();
        check("t3_no_cs", cs_count - cs_before, 0);

        // 4: A waits while B writes address 7, then reads it back
        b_req_valid = 1; b_req_we = 1; b_req_addr = 4'h7; b_req_wdata = 32'h7777_ABCD;
        #1;
        tick();
        b_req_valid = 0;
        a_req_valid = 1; a_req_we = 0; a_req_addr = 4'h7;
        #1;
        check("t4_a_blocked", a_req_ready, 0);
        check("t4_write_data", ram_data, 32'h7777_ABCD);
        tick();
        check("t4_b_rsp", b_rsp_valid, 1);
        check("t4_a_ready", a_req_ready, 1);
        tick();
        a_req_valid = 0;
        tick(); tick();
        check("t4_a_rsp", {a_rsp_valid, a_rsp_err}, 2'b10);
        check("t4_a_rdata", a_rsp_rdata, 32'h7777_ABCD);
        tick();

        // 5: reset during RD_ADDR abandons the read
        a_req_valid = 1; a_req_we = 0; a_req_addr = 4'h3;
        #1;
        tick();
        a_req_valid = 0;
        check("t5_in_rd_addr", {ram_cs, ram_oe}, 2'b10);
        rst = 1;
        tick();
        check("t5_idle", {busy, ram_cs, ram_we, ram_oe}, 0);
        check("t5_addr", ram_addr, 0);
        check("t5_no_rsp_at_rst", a_rsp_valid, 0);
        rst = 0;
        cnt = 0;
        repeat (4) begin
            if (a_rsp_valid) cnt++;
            tick();
        end
        check("t5_no_rsp", cnt, 0);

        // 6: fill all valid words then read them back on alternating ports
        for (int i = 0; i < 8; i++) begin
            do_txn(0, 1, 4'(i), 32'(i * 32'h11), rd, er, lat);
            check($sformatf("t6_w%0d_lat", i), lat, 1);
            check($sformatf("t6_w%0d_rsp", i), {er, rd}, 0);
        end
        for (int i = 0; i < 8; i++) begin
            do_txn(1'(i % 2), 0, 4'(i), '0, rd, er, lat);
            check($sformatf("t6_r%0d_lat", i), lat, 2);
            check($sformatf("t6_r%0d_err", i), er, 0);
            check($sformatf("t6_r%0d_data", i), rd, 32'(i * 32'h11));
        end
        tick(); tick();

        check("bus_conflicts", bus_conflicts, 0);
        check("rsp_protocol", rsp_bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
